riscv_instr_stream_gen: RTL and testbench
=========================================

RISCV_INSTR_STREAM_GEN -- requirements
Module: riscv_instr_stream_gen

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of encoded-instruction entries buffered (power of two, >=2).
REQ-002 Parameter NOP_FILL, default 1, 1 = serve NOP when FIFO empty, 0 = withhold grant when FIFO empty.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cmd_valid_i  input  1  encode command present.
REQ-006 cmd_ready_o  output  1  command accepted this cycle when high with cmd_valid_i.
REQ-007 cmd_op_i  input  6  operation code, instr_op_e from shared package.
REQ-008 cmd_rd_i, cmd_rs1_i, cmd_rs2_i  input  5 each  register indices.
REQ-009 cmd_imm_i  input  32  immediate, or CSR address in bits [11:0] for CSR ops.
REQ-010 cmd_err_o  output  1  one-cycle pulse, handshaken command had undefined cmd_op_i.
REQ-011 flush_i  input  1  discard all queued entries.
REQ-012 instr_req_i  input  1  core fetch request.
REQ-013 instr_addr_i  input  32  fetch address, ignored for data selection.
REQ-014 instr_gnt_o  output  1  fetch granted this cycle.
REQ-015 instr_rvalid_o  output  1  fetch data valid.
REQ-016 instr_rdata_o  output  32  encoded instruction word.
REQ-017 issued_cnt_o  output  32  count of non-NOP-fill words delivered.
REQ-018 empty_o, full_o  output  1 each  FIFO status.

Function
REQ-019 Supported ops: LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU, ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI, ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, MUL, MULH, DIV, DIVU, REM, REMU, CSRRW, CSRRS, CSRRC, ECALL, EBREAK, MRET, WFI, FENCE_I.
REQ-020 Encoding is combinational from cmd inputs, per RV32IM base formats: R, I, S/B, U, J; funct3/funct7/opcode values from shared package.
REQ-021 Immediate slicing: I-type imm[11:0]; B-type imm[12:1]; U-type imm[31:12]; J-type imm[20:1]; shift-immediates imm[4:0]; higher/lower bits beyond the field are dropped, no error.
REQ-022 ECALL/EBREAK/MRET/WFI/FENCE_I ignore rd/rs/imm and emit fixed words.
REQ-023 cmd_ready_o = !full_o; a pop in the same cycle does not free space for a push.
REQ-024 Handshake with undefined op: command consumed, nothing enqueued, cmd_err_o high next cycle for one cycle.
REQ-025 instr_gnt_o = instr_req_i && (!empty_o || NOP_FILL); grant pops FIFO head when non-empty.
REQ-026 instr_rvalid_o high exactly one cycle after each grant; instr_rdata_o holds the popped word, or 32'h00000013 when granted while empty; rdata holds last value when rvalid low.
REQ-027 Back-to-back grants are allowed; one word per cycle throughput.
REQ-028 issued_cnt_o increments at rvalid of a popped word only; wraps at 2^32.
REQ-029 flush_i clears FIFO pointers next edge, has priority over push and pop in the same cycle (push dropped, no grant from FIFO that cycle); an rvalid already owed from a previous-cycle grant is still delivered with its latched word.
REQ-030 FIFO ordering strict first-in-first-out; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-031 rst_n low: FIFO empty, instr_rvalid_o=0, instr_rdata_o=0, cmd_err_o=0, issued_cnt_o=0, pending rvalid discarded; empty_o=1, full_o=0.

Structure
REQ-032 instr_op_e, opcode/funct3/funct7 constants and NOP word live in a shared package alongside the existing decoder definitions.
REQ-033 Encoder is a separate combinational sub-module riscv_instr_encoder (op, regs, imm -> word, illegal flag); FIFO and handshake stay in top.

Verification
REQ-034 ADDI rd=1 rs1=0 imm=5, then fetch -> rvalid next cycle, rdata 32'h00500093, issued_cnt 1.
REQ-035 LUI rd=2 imm=32'h12345000; ADD rd=3 rs1=1 rs2=2; two back-to-back fetches -> 32'h12345137 then 32'h002081B3 on consecutive cycles.
REQ-036 Push ECALL, MRET, WFI, EBREAK until full (depth 4) -> cmd_ready low with fifth command held; drain -> 32'h00000073, 32'h30200073, 32'h10500073, 32'h00100073.
REQ-037 Empty FIFO, NOP_FILL=1, fetch -> 32'h00000013, issued_cnt unchanged; NOP_FILL=0 -> gnt stays 0.
REQ-038 cmd_op_i undefined code 6'h3F -> cmd_err_o one-cycle pulse, empty_o stays 1.
REQ-039 Grant in cycle N, flush_i and rst_n deassertion tests: flush at N -> rvalid at N+1 with granted word, FIFO empty; rst_n low at N -> no rvalid, all outputs reset values.

Source files
------------

// File: rtl/riscv_instr_stream_gen_pkg.sv
// Shared definitions for the instruction stream generator: operation codes,
// RV32IM opcode/funct constants, fixed system words and format helpers.
package riscv_instr_stream_gen_pkg;

  typedef enum logic [5:0] {
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_MUL, OP_MULH, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
    OP_CSRRW, OP_CSRRS, OP_CSRRC,
    OP_ECALL, OP_EBREAK, OP_MRET, OP_WFI, OP_FENCE_I
  } instr_op_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;  // SUB / SRA / SRAI
  localparam logic [6:0] F7_MULD = 7'b0000001;  // M extension

  localparam logic [31:0] NOP_WORD     = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] ECALL_WORD   = 32'h0000_0073;
  localparam logic [31:0] EBREAK_WORD  = 32'h0010_0073;
  localparam logic [31:0] MRET_WORD    = 32'h3020_0073;
  localparam logic [31:0] WFI_WORD     = 32'h1050_0073;
  localparam logic [31:0] FENCE_I_WORD = 32'h0000_100F;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:1] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
  endfunction

  function automatic logic [31:0] enc_u(input logic [31:12] imm, input logic [4:0] rd,
      input logic [6:0] opc);
    return {imm, rd, opc};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:1] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
  endfunction

endpackage

// File: rtl/riscv_instr_stream_gen_encoder.sv
// Combinational RV32IM encoder.
// op_i/rd_i/rs1_i/rs2_i/imm_i : command fields (imm_i[11:0] = CSR address for CSR ops)
// word_o                      : encoded instruction (NOP when illegal)
// illegal_o                   : op_i is not a defined operation
module riscv_instr_encoder
  import riscv_instr_stream_gen_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  always_comb begin
    word_o    = NOP_WORD;
    illegal_o = 1'b0;
    case (instr_op_e'(op_i))
      OP_LUI:    word_o = enc_u(imm_i[31:12], rd_i, OPC_LUI);
      OP_AUIPC:  word_o = enc_u(imm_i[31:12], rd_i, OPC_AUIPC);
      OP_JAL:    word_o = enc_j(imm_i[20:1], rd_i);
      OP_JALR:   word_o = enc_i(imm_i[11:0], rs1_i, 3'b000, rd_i, OPC_JALR);
      OP_BEQ:    word_o = enc_b(imm_i[12:1], rs2_i, rs1_i, 3'b000);
      OP_BNE:    word_o = enc_b(imm_i[12:1], rs2_i, rs1_i, 3'b001);
      OP_BLT:    word_o = enc_b(imm_i[12:1], rs2_i, rs1_i, 3'b100);
      OP_BGE:    word_o = enc_b(imm_i[12:1], rs2_i, rs1_i, 3'b101);
      OP_BLTU:   word_o = enc_b(imm_i[12:1], rs2_i, rs1_i, 3'b110);
      OP_BGEU:   word_o = enc_b(imm_i[12:1], rs2_i, rs1_i, 3'b111);
      OP_ADDI:   word_o = enc_i(imm_i[11:0], rs1_i, 3'b000, rd_i, OPC_OPIMM);
      OP_SLTI:   word_o = enc_i(imm_i[11:0], rs1_i, 3'b010, rd_i, OPC_OPIMM);
      OP_SLTIU:  word_o = enc_i(imm_i[11:0], rs1_i, 3'b011, rd_i, OPC_OPIMM);
      OP_XORI:   word_o = enc_i(imm_i[11:0], rs1_i, 3'b100, rd_i, OPC_OPIMM);
      OP_ORI:    word_o = enc_i(imm_i[11:0], rs1_i, 3'b110, rd_i, OPC_OPIMM);
      OP_ANDI:   word_o = enc_i(imm_i[11:0], rs1_i, 3'b111, rd_i, OPC_OPIMM);
      // shift-immediates carry shamt in the rs2 slot
      OP_SLLI:   word_o = enc_r(F7_BASE, imm_i[4:0], rs1_i, 3'b001, rd_i, OPC_OPIMM);
      OP_SRLI:   word_o = enc_r(F7_BASE, imm_i[4:0], rs1_i, 3'b101, rd_i, OPC_OPIMM);
      OP_SRAI:   word_o = enc_r(F7_ALT,  imm_i[4:0], rs1_i, 3'b101, rd_i, OPC_OPIMM);
      OP_ADD:    word_o = enc_r(F7_BASE, rs2_i, rs1_i, 3'b000, rd_i, OPC_OP);
      OP_SUB:    word_o = enc_r(F7_ALT,  rs2_i, rs1_i, 3'b000, rd_i, OPC_OP);
      OP_SLL:    word_o = enc_r(F7_BASE, rs2_i, rs1_i, 3'b001, rd_i, OPC_OP);
      OP_SLT:    word_o = enc_r(F7_BASE, rs2_i, rs1_i, 3'b010, rd_i, OPC_OP);
      OP_SLTU:   word_o = enc_r(F7_BASE, rs2_i, rs1_i, 3'b011, rd_i, OPC_OP);
      OP_XOR:    word_o = enc_r(F7_BASE, rs2_i, rs1_i, 3'b100, rd_i, OPC_OP);
      OP_SRL:    word_o = enc_r(F7_BASE, rs2_i, rs1_i, 3'b101, rd_i, OPC_OP);
      OP_SRA:    word_o = enc_r(F7_ALT,  rs2_i, rs1_i, 3'b101, rd_i, OPC_OP);
      OP_OR:     word_o = enc_r(F7_BASE, rs2_i, rs1_i, 3'b110, rd_i, OPC_OP);
      OP_AND:    word_o = enc_r(F7_BASE, rs2_i, rs1_i, 3'b111, rd_i, OPC_OP);
      OP_MUL:    word_o = enc_r(F7_MULD, rs2_i, rs1_i, 3'b000, rd_i, OPC_OP);
      OP_MULH:   word_o = enc_r(F7_MULD, rs2_i, rs1_i, 3'b001, rd_i, OPC_OP);
      OP_DIV:    word_o = enc_r(F7_MULD, rs2_i, rs1_i, 3'b100, rd_i, OPC_OP);
      OP_DIVU:   word_o = enc_r(F7_MULD, rs2_i, rs1_i, 3'b101, rd_i, OPC_OP);
      OP_REM:    word_o = enc_r(F7_MULD, rs2_i, rs1_i, 3'b110, rd_i, OPC_OP);
      OP_REMU:   word_o = enc_r(F7_MULD, rs2_i, rs1_i, 3'b111, rd_i, OPC_OP);
      OP_CSRRW:  word_o = enc_i(imm_i[11:0], rs1_i, 3'b001, rd_i, OPC_SYSTEM);
      OP_CSRRS:  word_o = enc_i(imm_i[11:0], rs1_i, 3'b010, rd_i, OPC_SYSTEM);
      OP_CSRRC:  word_o = enc_i(imm_i[11:0], rs1_i, 3'b011, rd_i, OPC_SYSTEM);
      OP_ECALL:  word_o = ECALL_WORD;
      OP_EBREAK: word_o = EBREAK_WORD;
      OP_MRET:   word_o = MRET_WORD;
      OP_WFI:    word_o = WFI_WORD;
      OP_FENCE_I: word_o = FENCE_I_WORD;
      default:   illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_instr_stream_gen.sv
// Instruction stream generator: encodes commands into RV32IM words, buffers
// them in a FIFO and serves them to a core fetch port (gnt, then rvalid+rdata
// one cycle later). Empty FIFO serves NOP when NOP_FILL=1.
// cmd_*      : encode command handshake, cmd_err_o pulses for undefined ops
// flush_i    : drop all queued words
// instr_*    : fetch port (address not used for selection)
// issued_cnt_o, empty_o, full_o : status
module riscv_instr_stream_gen
  import riscv_instr_stream_gen_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter bit NOP_FILL   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [5:0]  cmd_op_i,
  input  logic [4:0]  cmd_rd_i,
  input  logic [4:0]  cmd_rs1_i,
  input  logic [4:0]  cmd_rs2_i,
  input  logic [31:0] cmd_imm_i,
  output logic        cmd_err_o,
  input  logic        flush_i,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic [31:0] issued_cnt_o,
  output logic        empty_o,
  output logic        full_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [31:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wptr, r_rptr;   // extra MSB distinguishes full from empty
  logic        r_rvalid, r_err;
  logic [31:0] r_rdata, r_cnt;

  logic [31:0] w_word;
  logic        w_illegal, w_hs, w_push, w_fifo_rd, w_pop;
  logic        w_unused_addr;

  assign w_unused_addr = ^instr_addr_i;

  riscv_instr_encoder u_enc (
    .op_i      (cmd_op_i),
    .rd_i      (cmd_rd_i),
    .rs1_i     (cmd_rs1_i),
    .rs2_i     (cmd_rs2_i),
    .imm_i     (cmd_imm_i),
    .word_o    (w_word),
    .illegal_o (w_illegal)
  );

  assign empty_o     = (r_wptr == r_rptr);
  assign full_o      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign cmd_ready_o = !full_o;

  assign w_hs   = cmd_valid_i && cmd_ready_o;
  assign w_push = w_hs && !w_illegal && !flush_i;
  // During a flush the FIFO is treated as empty: no pop, NOP served if allowed.
  assign w_fifo_rd   = !empty_o && !flush_i;
  assign instr_gnt_o = instr_req_i && (w_fifo_rd || NOP_FILL);
  assign w_pop       = instr_req_i && w_fifo_rd;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= w_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      if (flush_i) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
      r_rvalid <= instr_gnt_o;
      if (instr_gnt_o) r_rdata <= w_pop ? r_mem[r_rptr[AW-1:0]] : NOP_WORD;
      // counter moves on the same edge that raises rvalid for a popped word
      if (w_pop) r_cnt <= r_cnt + 32'd1;
      r_err <= w_hs && w_illegal;
    end
  end

  assign instr_rvalid_o = r_rvalid;
  assign instr_rdata_o  = r_rdata;
  assign issued_cnt_o   = r_cnt;
  assign cmd_err_o      = r_err;

endmodule

// File: tb/tb_riscv_instr_stream_gen.sv
module tb_riscv_instr_stream_gen;
  import riscv_instr_stream_gen_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, flush, req;
  logic [5:0]  cmd_op;
  logic [4:0]  cmd_rd, cmd_rs1, cmd_rs2;
  logic [31:0] cmd_imm, addr, exp_word;

  logic        rdy1, err1, gnt1, rv1, emp1, full1;
  logic [31:0] rd1, cnt1;
  logic        rdy0, err0, gnt0, rv0, emp0, full0;
  logic [31:0] rd0, cnt0;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  riscv_instr_stream_gen #(.FIFO_DEPTH(DEPTH), .NOP_FILL(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(rdy1),
    .cmd_op_i(cmd_op), .cmd_rd_i(cmd_rd), .cmd_rs1_i(cmd_rs1), .cmd_rs2_i(cmd_rs2),
    .cmd_imm_i(cmd_imm), .cmd_err_o(err1), .flush_i(flush), .instr_req_i(req),
    .instr_addr_i(addr), .instr_gnt_o(gnt1), .instr_rvalid_o(rv1), .instr_rdata_o(rd1),
    .issued_cnt_o(cnt1), .empty_o(emp1), .full_o(full1));

  riscv_instr_stream_gen #(.FIFO_DEPTH(DEPTH), .NOP_FILL(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(rdy0),
    .cmd_op_i(cmd_op), .cmd_rd_i(cmd_rd), .cmd_rs1_i(cmd_rs1), .cmd_rs2_i(cmd_rs2),
    .cmd_imm_i(cmd_imm), .cmd_err_o(err0), .flush_i(flush), .instr_req_i(req),
    .instr_addr_i(addr), .instr_gnt_o(gnt0), .instr_rvalid_o(rv0), .instr_rdata_o(rd0),
    .issued_cnt_o(cnt0), .empty_o(emp0), .full_o(full0));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Queue of expected words; the word for each command comes from the
  // stimulus (hand-computed), so the model only tracks ordering/handshake.
  logic [31:0] q[$];
  logic        m_rv, m_err, m0_rv;
  logic [31:0] m_rd, m_cnt, m0_rd;

  always @(posedge clk or negedge rst_n) begin
    logic acc, legal, pop;
    logic [31:0] w;
    if (!rst_n) begin
      q.delete();
      m_rv <= 1'b0; m_rd <= '0; m_cnt <= '0; m_err <= 1'b0;
      m0_rv <= 1'b0; m0_rd <= '0;
    end else begin
      acc   = cmd_valid && (q.size() < DEPTH);
      legal = (cmd_op <= 6'd42);
      pop   = req && (q.size() > 0) && !flush;
      w     = NOP;
      if (pop) w = q.pop_front();
      if (flush) q.delete();
      else if (acc && legal) q.push_back(exp_word);
      m_err <= acc && !legal;
      m_rv  <= req;
      if (req) m_rd <= w;
      if (pop) m_cnt <= m_cnt + 32'd1;
      m0_rv <= pop;
      if (pop) m0_rd <= w;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready",   {31'd0, rdy1},  {31'd0, q.size() < DEPTH});
      chk("empty",   {31'd0, emp1},  {31'd0, q.size() == 0});
      chk("full",    {31'd0, full1}, {31'd0, q.size() == DEPTH});
      chk("gnt",     {31'd0, gnt1},  {31'd0, req});
      chk("rvalid",  {31'd0, rv1},   {31'd0, m_rv});
      chk("rdata",   rd1, m_rd);
      chk("cnt",     cnt1, m_cnt);
      chk("err",     {31'd0, err1},  {31'd0, m_err});
      chk("gnt0",    {31'd0, gnt0},  {31'd0, req && q.size() > 0 && !flush});
      chk("rvalid0", {31'd0, rv0},   {31'd0, m0_rv});
      chk("rdata0",  rd0, m0_rd);
      chk("cnt0",    cnt0, m_cnt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_cmd(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm, input logic [31:0] ew);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
    cmd_imm = imm; exp_word = ew;
  endtask

  task automatic push(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm, input logic [31:0] ew);
    set_cmd(op, rd, rs1, rs2, imm, ew);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  typedef struct {logic [5:0] op; logic [4:0] rd, rs1, rs2; logic [31:0] imm, w;} vec_t;
  vec_t tbl[$];

  task automatic add(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [31:0] imm, input logic [31:0] w);
    vec_t v;
    v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.w = w;
    tbl.push_back(v);
  endtask

  initial begin
    logic [31:0] exp_q[$];
    logic [31:0] cnt_save;
    rst_n = 1'b0; cmd_valid = 0; flush = 0; req = 0; cmd_op = 0; cmd_rd = 0;
    cmd_rs1 = 0; cmd_rs2 = 0; cmd_imm = 0; addr = 32'h8000_0000; exp_word = 0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    chk("rst empty", {31'd0, emp1}, 32'd1);
    chk("rst full", {31'd0, full1}, 32'd0);
    chk("rst rvalid", {31'd0, rv1}, 32'd0);
    chk("rst rdata", rd1, 32'd0);
    chk("rst cnt", cnt1, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // single ADDI then fetch
    push(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093);
    req = 1; @(posedge clk); #1; req = 0;
    chk("addi rvalid", {31'd0, rv1}, 32'd1);
    chk("addi rdata", rd1, 32'h0050_0093);
    chk("addi cnt", cnt1, 32'd1);

    // LUI + ADD, back-to-back fetch
    push(OP_LUI, 5'd2, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_5137);
    push(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0020_81B3);
    req = 1; @(posedge clk); #1;
    chk("lui rdata", rd1, 32'h1234_5137);
    @(posedge clk); #1; req = 0;
    chk("add rdata", rd1, 32'h0020_81B3);
    chk("add rvalid", {31'd0, rv1}, 32'd1);

    // encoding table, in chunks of FIFO depth, drained back-to-back
    add(OP_SUB,  5'd5,  5'd6,  5'd7, 32'd0,          32'h4073_02B3);
    add(OP_SRAI, 5'd10, 5'd11, 5'd0, 32'h0000_0023,  32'h4035_D513);
    add(OP_JAL,  5'd1,  5'd0,  5'd0, 32'h0000_0800,  32'h0010_00EF);
    add(OP_BEQ,  5'd0,  5'd1,  5'd2, 32'h0000_0800,  32'h0020_80E3);
    add(OP_BNE,  5'd0,  5'd0,  5'd0, 32'hFFFF_FFFC,  32'hFE00_1EE3);
    add(OP_CSRRW,5'd1,  5'd2,  5'd0, 32'h0000_0300,  32'h3001_10F3);
    add(OP_MUL,  5'd3,  5'd4,  5'd5, 32'd0,          32'h0252_01B3);
    add(OP_FENCE_I, 5'd9, 5'd9, 5'd9, 32'hFFFF_FFFF, 32'h0000_100F);
    add(OP_JALR, 5'd0,  5'd1,  5'd0, 32'd0,          32'h0000_8067);
    add(OP_AUIPC,5'd5,  5'd0,  5'd0, 32'hFFFF_F000,  32'hFFFF_F297);
    for (int i = 0; i < tbl.size(); i += DEPTH) begin
      int n;
      n = (tbl.size() - i < DEPTH) ? tbl.size() - i : DEPTH;
      for (int k = 0; k < n; k++)
        push(tbl[i+k].op, tbl[i+k].rd, tbl[i+k].rs1, tbl[i+k].rs2, tbl[i+k].imm, tbl[i+k].w);
      req = 1;
      for (int k = 0; k < n; k++) begin
        @(posedge clk); #1;
        chk($sformatf("enc[%0d]", i + k), rd1, tbl[i+k].w);
      end
      req = 0;
    end

    // fill with system ops, fifth command held until space frees
    push(OP_ECALL,  5'd7, 5'd7, 5'd7, 32'h1234, 32'h0000_0073);
    push(OP_MRET,   5'd1, 5'd2, 5'd3, 32'd0,    32'h3020_0073);
    push(OP_WFI,    5'd0, 5'd0, 5'd0, 32'hFF,   32'h1050_0073);
    push(OP_EBREAK, 5'd4, 5'd0, 5'd0, 32'd0,    32'h0010_0073);
    chk("full flag", {31'd0, full1}, 32'd1);
    set_cmd(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093);
    @(posedge clk); #1;
    chk("full ready", {31'd0, rdy1}, 32'd0);
    exp_q = '{32'h0000_0073, 32'h3020_0073, 32'h1050_0073, 32'h0010_0073, 32'h0050_0093};
    req = 1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (k == 1) cmd_valid = 1'b0;
      chk($sformatf("drain[%0d]", k), rd1, exp_q[k]);
    end
    req = 0;

    // empty fetch: NOP with NOP_FILL=1, no grant with NOP_FILL=0
    cnt_save = cnt1;
    req = 1; #1;
    chk("nofill gnt", {31'd0, gnt0}, 32'd0);
    chk("fill gnt", {31'd0, gnt1}, 32'd1);
    @(posedge clk); #1; req = 0;
    chk("nop rdata", rd1, NOP);
    chk("nop cnt", cnt1, cnt_save);
    chk("nofill rvalid", {31'd0, rv0}, 32'd0);

    // undefined op
    push(6'h3F, 5'd1, 5'd1, 5'd1, 32'd1, 32'hDEAD_BEEF);
    chk("illegal err", {31'd0, err1}, 32'd1);
    chk("illegal empty", {31'd0, emp1}, 32'd1);
    @(posedge clk); #1;
    chk("illegal err pulse", {31'd0, err1}, 32'd0);

    // flush after a grant: owed rvalid delivered, queue cleared, push dropped
    push(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093);
    push(OP_LUI, 5'd2, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_5137);
    req = 1; @(posedge clk); #1;
    flush = 1;
    set_cmd(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0020_81B3);
    chk("flush owed rvalid", {31'd0, rv1}, 32'd1);
    chk("flush owed rdata", rd1, 32'h0050_0093);
    @(posedge clk); #1;
    flush = 0; req = 0; cmd_valid = 0;
    chk("flush empty", {31'd0, emp1}, 32'd1);
    chk("flush nop", rd1, NOP);
    @(posedge clk); #1;
    chk("rdata hold", rd1, NOP);

    // reset while a grant is in flight
    push(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093);
    req = 1; rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst rvalid2", {31'd0, rv1}, 32'd0);
    chk("rst rdata2", rd1, 32'd0);
    chk("rst cnt2", cnt1, 32'd0);
    chk("rst empty2", {31'd0, emp1}, 32'd1);
    req = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    push(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093);
    req = 1; @(posedge clk); #1; req = 0;
    chk("post rst cnt", cnt1, 32'd1);
    chk("post rst rdata", rd1, 32'h0050_0093);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
